// File: rtl/proc_mcycle_ctrl.sv
// Multicycle control unit for the TinyRV1 core: sequences fetch, execute,
// memory and multiply phases over val/rdy memory handshakes and counts retirements.
module proc_mcycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_val,
    input  logic        imem_req_rdy,
    input  logic        imem_resp_val,
    output logic        dmem_req_val,
    output logic        dmem_req_type,
    input  logic        dmem_req_rdy,
    input  logic        dmem_resp_val,
    output logic        ir_en,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        op2_sel,
    output logic [1:0]  imm_type,
    output logic        alu_func,
    output logic [1:0]  wb_sel,
    output logic        rf_wen,
    output logic        mul_start,
    input  logic        mul_done,
    input  logic [31:0] inst,
    input  logic        alu_eq,
    output logic        retire_val,
    output logic [31:0] inst_count,
    output logic        halted
);

    typedef enum logic [2:0] {
        FETCH,
        FWAIT,
        EXEC,
        DMEM,
        MUL,
        HALT
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] count_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic is_add, is_addi, is_mul, is_lw, is_sw, is_jal, is_jr, is_bne;
    logic unused_inst_fields;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign unused_inst_fields = ^{inst[24:15], inst[11:7]};

    assign is_add  = (opcode == OPC_OP) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_mul  = (opcode == OPC_OP) && (funct3 == 3'b000) && (funct7 == 7'b0000001);
    assign is_addi = (opcode == OPC_OP_IMM) && (funct3 == 3'b000);
    assign is_lw   = (opcode == OPC_LOAD)   && (funct3 == 3'b010);
    assign is_sw   = (opcode == OPC_STORE)  && (funct3 == 3'b010);
    assign is_jal  = (opcode == OPC_JAL);
    assign is_jr   = (opcode == OPC_JALR)   && (funct3 == 3'b000);
    assign is_bne  = (opcode == OPC_BRANCH) && (funct3 == 3'b001);

    // Outputs are forced low while rst is high so nothing leaks out before the
    // synchronous reset has taken effect on the state register.
    always_comb begin
        state_d       = state_q;
        imem_req_val  = 1'b0;
        dmem_req_val  = 1'b0;
        dmem_req_type = 1'b0;
        ir_en         = 1'b0;
        pc_en         = 1'b0;
        pc_sel        = 2'd0;
        op2_sel       = 1'b0;
        imm_type      = 2'd0;
        alu_func      = 1'b0;
        wb_sel        = 2'd0;
        rf_wen        = 1'b0;
        mul_start     = 1'b0;
        retire_val    = 1'b0;
        halted        = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    imem_req_val = 1'b1;
                    if (imem_req_rdy) state_d = FWAIT;
                end
                FWAIT: begin
                    if (imem_resp_val) begin
                        ir_en   = 1'b1;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    if (is_add || is_addi) begin
                        op2_sel    = is_addi;
                        wb_sel     = 2'd2;
                        rf_wen     = 1'b1;
                        pc_en      = 1'b1;
                        retire_val = 1'b1;
                        state_d    = FETCH;
                    end else if (is_mul) begin
                        mul_start = 1'b1;
                        state_d   = MUL;
                    end else if (is_lw || is_sw) begin
                        op2_sel       = 1'b1;
                        imm_type      = is_sw ? 2'd1 : 2'd0;
                        dmem_req_val  = 1'b1;
                        dmem_req_type = is_sw;
                        if (dmem_req_rdy) state_d = DMEM;
                    end else if (is_jal) begin
                        imm_type   = 2'd2;
                        pc_sel     = 2'd1;
                        rf_wen     = 1'b1;
                        pc_en      = 1'b1;
                        retire_val = 1'b1;
                        state_d    = FETCH;
                    end else if (is_jr) begin
                        pc_sel     = 2'd2;
                        pc_en      = 1'b1;
                        retire_val = 1'b1;
                        state_d    = FETCH;
                    end else if (is_bne) begin
                        alu_func   = 1'b1;
                        imm_type   = 2'd3;
                        pc_sel     = alu_eq ? 2'd0 : 2'd1;
                        pc_en      = 1'b1;
                        retire_val = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = HALT;
                    end
                end
                DMEM: begin
                    // The IR is untouched until the next fetch, so LW/SW is re-decoded here.
                    op2_sel  = 1'b1;
                    imm_type = is_sw ? 2'd1 : 2'd0;
                    if (dmem_resp_val) begin
                        pc_en      = 1'b1;
                        retire_val = 1'b1;
                        if (is_lw) begin
                            rf_wen = 1'b1;
                            wb_sel = 2'd3;
                        end
                        state_d = FETCH;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        wb_sel     = 2'd1;
                        rf_wen     = 1'b1;
                        pc_en      = 1'b1;
                        retire_val = 1'b1;
                        state_d    = FETCH;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retire_val) count_q <= count_q + 32'd1;
        end
    end

    assign inst_count = rst ? 32'd0 : count_q;

endmodule
